pulse_pacer: RTL and testbench
==============================

# pulse_pacer

Upstream pacing stage for the cross-domain pulse synchronizer, in the source clock domain. It accepts single-cycle event strobes at any rate, counts the events not yet forwarded, and re-issues them as single-cycle pulses spaced at least HOLDOFF+1 cycles apart. The spacing lets each pulse complete the synchronizer's request/acknowledge round trip, so no events merge. A sticky flag records any events lost to counter saturation.

## Interface

- CNT_W, default 4: width of the pending-event counter; maximum pending count is 2^CNT_W-1.
- HOLDOFF, default 8: number of idle cycles forced after every emitted pulse; legal range is 1 and up.
- clk  input  1  single clock, rising-edge.
- reset_  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- event_in  input  1  one event per cycle sampled high; back-to-back highs count as separate events.
- ovf_clr  input  1  clears ovf when sampled high.
- pulse_out  output  1  registered, one-cycle pulse per forwarded event; drives the synchronizer pulse input.
- pending  output  CNT_W  events accepted but not yet emitted, registered.
- busy  output  1  high when state is not IDLE or pending is non-zero.
- ovf  output  1  sticky flag: at least one event was dropped.

## Operation

- The block has three states: IDLE, PULSE and HOLD. pulse_out is high exactly when the state is PULSE.
- A launch is a transition into PULSE. It is allowed from IDLE, and from HOLD when hold_cnt==0, in both cases only when the registered pending value is non-zero.
  - An event arriving in the same cycle does not enable a launch that cycle.
- IDLE: if pending != 0, launch; otherwise stay in IDLE.
- PULSE: always lasts one cycle. Next state is HOLD, with hold_cnt loaded to HOLDOFF-1.
- HOLD: decrement hold_cnt each cycle. When hold_cnt==0, launch if pending != 0, otherwise go to IDLE.
- Pending arithmetic is pending_next = pending + inc - dec, where inc = event_in and dec = launch.
  - inc and dec in the same cycle leave pending unchanged.
  - If pending is at its maximum and inc=1 with dec=0, pending holds at maximum, the event is dropped, and ovf is set.
  - Pending never wraps.
- ovf:
  - ovf is set on a drop and cleared by ovf_clr.
  - If a drop and ovf_clr occur in the same cycle, set wins and ovf stays 1.
- hold_cnt width is clog2(HOLDOFF) bits, minimum 1 bit.
- reset_ low, at any time, immediately forces:
  - state to IDLE;
  - pulse_out, pending, busy, ovf and hold_cnt to 0.
  - No pulse is emitted for events that were pending at reset.

## Timing

- Reset values: pulse_out=0, pending=0, busy=0, ovf=0.
- Latency: an event sampled at edge E while the block is IDLE and pending is 0:
  - pending=1 after edge E;
  - pulse_out=1 and pending=0 after edge E+1;
  - pulse_out=0 after edge E+2 (the block is now in HOLD).
- Pulse period: the minimum spacing between rising edges of pulse_out is HOLDOFF+1 cycles. With a backlog, pulses are emitted at exactly this period.
- After the last pulse, the block returns to IDLE HOLDOFF+1 cycles after pulse_out rose. busy falls in the same cycle, provided pending==0.
- ovf rises the cycle after the dropping edge. ovf falls the cycle after ovf_clr is sampled, unless a drop occurs in that same cycle.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

## Test plan

- **Single event:** HOLDOFF=8. event_in high for one cycle at edge 10 → pending=1 after edge 10; pulse_out high only during cycle 11–12; busy drops after edge 20; ovf=0.
- **Burst of 3:** HOLDOFF=8. event_in high at edges 10, 11 and 12 → exactly three pulses, rising after edges 11, 20 and 29. pending sequence is 1, 1, 2, then decrements at each launch to 0.
- **Saturation:** CNT_W=2, HOLDOFF=8. event_in high at edges 10–14:
  - pending reaches 3 after edge 13;
  - the edge-14 event is dropped and ovf=1 after edge 14;
  - exactly 4 pulses are emitted in total.
- **Overflow clear:** continue from the saturation scenario.
  - ovf_clr high alone for one cycle → ovf=0 on the next cycle.
  - Repeat saturation with ovf_clr held high on the dropping edge → ovf=1.
- **Simultaneous inc/dec:** pending=1 in HOLD with hold_cnt==0, and event_in=1 on the same edge → launch occurs and pending stays 1.
- **Reset mid-operation:** assert reset_ while in HOLD with pending=2 → all outputs 0 immediately, without waiting for a clock. After release, no pulse appears until a new event arrives.

Source files
------------

// File: rtl/pulse_pacer.sv
// Pacing stage ahead of the cross-domain pulse synchronizer: counts incoming event
// strobes and re-issues them as single-cycle pulses spaced HOLDOFF+1 cycles apart.
module pulse_pacer #(
    parameter int CNT_W   = 4,
    parameter int HOLDOFF = 8
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             event_in,
    input  logic             ovf_clr,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             ovf
);

    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } pacerState_t;

    pacerState_t       r_state;
    pacerState_t       w_stateNext;
    logic [HC_W-1:0]   r_holdCnt;
    logic [HC_W-1:0]   w_holdCntNext;
    logic [CNT_W-1:0]  r_pending;
    logic [CNT_W-1:0]  w_pendingNext;
    logic              r_pulse;
    logic              r_busy;
    logic              r_ovf;
    logic              w_ovfNext;
    logic              w_launch;
    logic              w_drop;

    // A launch only looks at the registered backlog, so an event arriving this
    // cycle can never trigger a pulse in the same cycle.
    always_comb begin
        w_launch      = (r_pending != '0) &&
                        ((r_state == IDLE) || ((r_state == HOLD) && (r_holdCnt == '0)));
        w_stateNext   = r_state;
        w_holdCntNext = r_holdCnt;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_stateNext = PULSE;
                end
            end
            PULSE: begin
                w_stateNext   = HOLD;
                w_holdCntNext = HOLD_LOAD;
            end
            HOLD: begin
                if (r_holdCnt == '0) begin
                    w_stateNext = w_launch ? PULSE : IDLE;
                end else begin
                    w_holdCntNext = r_holdCnt - HC_W'(1);
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_holdCntNext = '0;
            end
        endcase
    end

    // Saturating backlog: a simultaneous launch frees a slot, so only an
    // unmatched event at full count is lost.
    always_comb begin
        w_drop        = event_in && !w_launch && (r_pending == PEND_MAX);
        w_pendingNext = r_pending;
        if (event_in && !w_launch && !w_drop) begin
            w_pendingNext = r_pending + CNT_W'(1);
        end else if (!event_in && w_launch) begin
            w_pendingNext = r_pending - CNT_W'(1);
        end
        w_ovfNext = w_drop || (r_ovf && !ovf_clr);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state   <= IDLE;
            r_holdCnt <= '0;
            r_pending <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_holdCnt <= w_holdCntNext;
            r_pending <= w_pendingNext;
            r_pulse   <= (w_stateNext == PULSE);
            r_busy    <= (w_stateNext != IDLE) || (w_pendingNext != '0);
            r_ovf     <= w_ovfNext;
        end
    end

    assign pulse_out = r_pulse;
    assign pending   = r_pending;
    assign busy      = r_busy;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pulse_pacer.sv
// Self-checking bench for pulse_pacer: directed scenarios plus random traffic,
// all compared against a cycle-count reference model of the pacing rules.
module tb_pulse_pacer;

    localparam int CNT_W   = 2;
    localparam int HOLDOFF = 8;
    localparam int PMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_;
    logic             event_in;
    logic             ovf_clr;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a launch happens whenever there is backlog and at least
    // HOLDOFF+1 edges have passed since the previous launch.
    int mPend;
    bit mOvf;
    bit mPulse;
    bit mBusy;
    int edgeNo = 0;
    int lastLaunch;

    logic [CNT_W+2:0] expVec;
    logic [CNT_W+2:0] actVec;

    pulse_pacer #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .event_in  (event_in),
        .ovf_clr   (ovf_clr),
        .pulse_out (pulse_out),
        .pending   (pending),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mPend      = 0;
        mOvf       = 1'b0;
        mPulse     = 1'b0;
        mBusy      = 1'b0;
        lastLaunch = -1000;
    endtask

    task automatic tick(input bit ev, input bit clr);
        bit launch;
        bit drop;
        event_in = ev;
        ovf_clr  = clr;
        @(posedge clk);
        edgeNo++;
        launch = (mPend > 0) && (edgeNo >= lastLaunch + HOLDOFF + 1);
        if (launch) lastLaunch = edgeNo;
        drop = ev && !launch && (mPend == PMAX);
        if (!drop) mPend = mPend + int'(ev) - int'(launch);
        mOvf   = drop ? 1'b1 : (clr ? 1'b0 : mOvf);
        mPulse = launch;
        mBusy  = (edgeNo <= lastLaunch + HOLDOFF) || (mPend != 0);
        expVec = {mPulse, CNT_W'(mPend), mBusy, mOvf};
        #1;
        actVec = {pulse_out, pending, busy, ovf};
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        event_in = 1'b0;
        ovf_clr = 1'b0;
        modelReset();
        #12;
        compared++;
        if ({pulse_out, pending, busy, ovf} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got %b want %b", {pulse_out, pending, busy, ovf}, 5'b0);
        end
        reset_ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0);
            compared++;
            if (actVec !== expVec) begin
                mismatched++;
                $display("[TB] FAIL reset_idle step %0d: got %b want %b", k, actVec, expVec);
            end
        end
    endtask

    task automatic test_single_event();
        tick(1'b1, 1'b0);
        compared++;
        if (pending !== CNT_W'(1) || pulse_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_accept: got pend=%0d pulse=%b want pend=1 pulse=0", pending, pulse_out);
        end
        for (int k = 1; k <= 14; k++) begin
            tick(1'b0, 1'b0);
            compared++;
            if (actVec !== expVec) begin
                mismatched++;
                $display("[TB] FAIL single_model step %0d: got %b want %b", k, actVec, expVec);
            end
            if (k == 1) begin
                compared++;
                if (pulse_out !== 1'b1 || pending !== '0) begin
                    mismatched++;
                    $display("[TB] FAIL single_pulse: got pulse=%b pend=%0d want pulse=1 pend=0", pulse_out, pending);
                end
            end
            if (k == 9 || k == 10) begin
                compared++;
                if (busy !== (k == 9)) begin
                    mismatched++;
                    $display("[TB] FAIL single_busy step %0d: got %b want %b", k, busy, (k == 9));
                end
            end
        end
    endtask

    task automatic test_burst();
        int pulseAt[$];
        int want[3] = '{1, 10, 19};
        for (int k = 0; k < 34; k++) begin
            tick(k < 3, 1'b0);
            compared++;
            if (actVec !== expVec) begin
                mismatched++;
                $display("[TB] FAIL burst_model step %0d: got %b want %b", k, actVec, expVec);
            end
            if (pulse_out === 1'b1) pulseAt.push_back(k);
        end
        compared++;
        if (pulseAt.size() != 3) begin
            mismatched++;
            $display("[TB] FAIL burst_count: got %0d want 3", pulseAt.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (pulseAt[i] != want[i]) begin
                    mismatched++;
                    $display("[TB] FAIL burst_spacing %0d: got %0d want %0d", i, pulseAt[i], want[i]);
                end
            end
        end
    endtask

    task automatic saturate(input bit clrOnDrop, input string tag);
        int pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick(k < 5, clrOnDrop && (k == 4));
            compared++;
            if (actVec !== expVec) begin
                mismatched++;
                $display("[TB] FAIL %s_model step %0d: got %b want %b", tag, k, actVec, expVec);
            end
            if (k == 3 || k == 4) begin
                compared++;
                if (pending !== CNT_W'(PMAX) || ovf !== (k == 4)) begin
                    mismatched++;
                    $display("[TB] FAIL %s_full step %0d: got pend=%0d ovf=%b want pend=%0d ovf=%b",
                             tag, k, pending, ovf, PMAX, (k == 4));
                end
            end
            if (pulse_out === 1'b1) pulses++;
        end
        compared++;
        if (pulses != 4) begin
            mismatched++;
            $display("[TB] FAIL %s_pulses: got %0d want 4", tag, pulses);
        end
    endtask

    task automatic test_saturation();
        saturate(1'b0, "sat");
    endtask

    task automatic test_ovf_clr();
        tick(1'b0, 1'b1);
        compared++;
        if (ovf !== 1'b0 || mOvf != 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_clear: got %b want 0", ovf);
        end
        saturate(1'b1, "satclr");
        tick(1'b0, 1'b1);
        compared++;
        if (actVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL ovf_reclear: got %b want %b", actVec, expVec);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 30; k++) begin
            tick(k == 0 || k == 2 || k == 10, 1'b0);
            compared++;
            if (actVec !== expVec) begin
                mismatched++;
                $display("[TB] FAIL b2b_model step %0d: got %b want %b", k, actVec, expVec);
            end
            if (k == 10) begin
                compared++;
                if (pulse_out !== 1'b1 || pending !== CNT_W'(1)) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_incdec: got pulse=%b pend=%0d want pulse=1 pend=1", pulse_out, pending);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5);
            compared++;
            if (actVec !== expVec) begin
                mismatched++;
                $display("[TB] FAIL random step %0d: got %b want %b", k, actVec, expVec);
            end
        end
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, 1'b1);
        end
        compared++;
        if (actVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL random_drain: got %b want %b", actVec, expVec);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0);
        end
        compared++;
        if (pending === '0 || ovf !== 1'b1 || actVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL rstmid_setup: got %b want %b", actVec, expVec);
        end
        #2;
        reset_ = 1'b0;
        #1;
        modelReset();
        compared++;
        if ({pulse_out, pending, busy, ovf} !== '0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_async: got %b want %b", {pulse_out, pending, busy, ovf}, 5'b0);
        end
        #2;
        reset_ = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b0);
            compared++;
            if (actVec !== expVec || pulse_out !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rstmid_quiet step %0d: got %b want %b", k, actVec, expVec);
            end
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        compared++;
        if (pulse_out !== 1'b1 || actVec !== expVec) begin
            mismatched++;
            $display("[TB] FAIL rstmid_newevent: got %b want %b", actVec, expVec);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_burst();
        test_saturation();
        test_ovf_clr();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
